// File: rtl/drive_mode_controller.sv
// ============================================================================
// Module      : drive_mode_controller
// Description : Behaviour scheduler arbitrating IR, audio and vision commands
//               into one registered motor command and speed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drive_mode_controller #(
    parameter int LOST_FRAMES    = 8,
    parameter int SEARCH_FRAMES  = 120,
    parameter int MANUAL_TIMEOUT = 25000000,
    parameter int MANUAL_SPEED   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ir_cmd,
    input  logic       ir_toggle,
    input  logic [3:0] audio_level,
    input  logic       fast,
    input  logic       orange_detected,
    input  logic [1:0] direction,
    input  logic       vsync,
    output logic [1:0] mode,
    output logic [2:0] motor_cmd,
    output logic [3:0] speed,
    output logic       cmd_valid
);

    localparam int LOST_W   = $clog2(LOST_FRAMES + 1);
    localparam int SEARCH_W = $clog2(SEARCH_FRAMES + 1);
    localparam int TIMER_W  = $clog2(MANUAL_TIMEOUT + 1);

    localparam logic [LOST_W-1:0]   LOST_LAST   = LOST_W'(LOST_FRAMES - 1);
    localparam logic [LOST_W-1:0]   LOST_MAX    = LOST_W'(LOST_FRAMES);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_FRAMES - 1);
    localparam logic [SEARCH_W-1:0] SEARCH_MAX  = SEARCH_W'(SEARCH_FRAMES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(MANUAL_TIMEOUT - 1);
    localparam logic [3:0]          MAN_SPEED   = 4'(MANUAL_SPEED);

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_TRACK  = 2'b10;
    localparam logic [1:0] MODE_SEARCH = 2'b11;

    localparam logic [2:0] MOT_STOP  = 3'd0;
    localparam logic [2:0] MOT_FWD   = 3'd1;
    localparam logic [2:0] MOT_LEFT  = 3'd3;
    localparam logic [2:0] MOT_RIGHT = 3'd4;

    localparam logic [2:0] IR_NONE   = 3'd0;
    localparam logic [2:0] IR_STOP   = 3'd5;
    localparam logic [2:0] IR_AUTO   = 3'd6;
    localparam logic [2:0] IR_MANUAL = 3'd7;

    logic [1:0]          mode_q, mode_d;
    logic [2:0]          motor_q, motor_d;
    logic [3:0]          speed_q, speed_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic [SEARCH_W-1:0] search_q, search_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                ir_toggle_q, ir_toggle_d;
    logic                vsync_q, vsync_d;
    logic                armed_q, armed_d;

    logic                ir_event;
    logic                frame_tick;
    logic [2:0]          track_motor;
    logic [3:0]          audio_speed;

    function automatic logic [2:0] steer(input logic [1:0] dir);
        case (dir)
            2'b01:   steer = MOT_LEFT;
            2'b10:   steer = MOT_RIGHT;
            default: steer = MOT_FWD;
        endcase
    endfunction

    always_comb begin
        armed_d     = 1'b1;
        ir_toggle_d = ir_toggle;
        vsync_d     = vsync;
        mode_d      = mode_q;
        motor_d     = motor_q;
        timer_d     = timer_q;
        lost_d      = lost_q;
        search_d    = search_q;

        // The first cycle after reset only loads the edge detectors, so input
        // levels that differ from the reset values cannot fake an event.
        ir_event    = armed_q && (ir_toggle != ir_toggle_q) && (ir_cmd != IR_NONE);
        frame_tick  = armed_q && vsync_q && !vsync;
        track_motor = steer(direction);

        if (mode_q == MODE_MANUAL) begin
            if (timer_q == TIMER_LAST) begin
                motor_d = MOT_STOP;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end

        if (ir_event) begin
            case (ir_cmd)
                IR_STOP: begin
                    mode_d  = MODE_IDLE;
                    motor_d = MOT_STOP;
                end
                IR_MANUAL: begin
                    mode_d  = MODE_MANUAL;
                    motor_d = MOT_STOP;
                    timer_d = '0;
                end
                IR_AUTO: begin
                    mode_d = MODE_TRACK;
                    lost_d = '0;
                end
                default: begin
                    mode_d  = MODE_MANUAL;
                    motor_d = ir_cmd;
                    timer_d = '0;
                end
            endcase
        end else if (frame_tick) begin
            if (mode_q == MODE_TRACK) begin
                if (orange_detected) begin
                    lost_d  = '0;
                    motor_d = track_motor;
                end else if (lost_q >= LOST_LAST) begin
                    mode_d   = MODE_SEARCH;
                    lost_d   = LOST_MAX;
                    search_d = '0;
                    motor_d  = MOT_LEFT;
                end else begin
                    lost_d = lost_q + LOST_W'(1);
                end
            end else if (mode_q == MODE_SEARCH) begin
                if (orange_detected) begin
                    mode_d  = MODE_TRACK;
                    lost_d  = '0;
                    motor_d = track_motor;
                end else if (search_q >= SEARCH_LAST) begin
                    mode_d   = MODE_IDLE;
                    search_d = SEARCH_MAX;
                    motor_d  = MOT_STOP;
                end else begin
                    search_d = search_q + SEARCH_W'(1);
                end
            end
        end

        // Speed follows the next mode/motor so both change in the same cycle.
        audio_speed = fast ? audio_level : {1'b0, audio_level[3:1]};
        case (mode_d)
            MODE_IDLE:   speed_d = 4'd0;
            MODE_MANUAL: speed_d = (motor_d != MOT_STOP) ? MAN_SPEED : 4'd0;
            default: begin
                speed_d = audio_speed;
                if ((motor_d != MOT_STOP) && (audio_speed == 4'd0)) begin
                    speed_d = 4'd1;
                end
            end
        endcase

        cmd_valid_d = (motor_d != motor_q) || (speed_d != speed_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_IDLE;
            motor_q     <= MOT_STOP;
            speed_q     <= 4'd0;
            cmd_valid_q <= 1'b0;
            lost_q      <= '0;
            search_q    <= '0;
            timer_q     <= '0;
            ir_toggle_q <= 1'b0;
            vsync_q     <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            motor_q     <= motor_d;
            speed_q     <= speed_d;
            cmd_valid_q <= cmd_valid_d;
            lost_q      <= lost_d;
            search_q    <= search_d;
            timer_q     <= timer_d;
            ir_toggle_q <= ir_toggle_d;
            vsync_q     <= vsync_d;
            armed_q     <= armed_d;
        end
    end

    assign mode      = mode_q;
    assign motor_cmd = motor_q;
    assign speed     = speed_q;
    assign cmd_valid = cmd_valid_q;

endmodule

`default_nettype wire
